// File: rtl/sdcard_spi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sdcard_spi_engine
//  Description : SD-card SPI master, SPI mode 0. After reset it runs the card
//                power-up sequence (CS high, MOSI high, INIT_CLOCKS slow SCLK
//                cycles). After that it executes single opcodes from the
//                command FSM above: byte transfer, CS control, rate select
//                and power-up re-run.
//  Ports       : clock, reset_n        - system clock, sync active-low reset
//                spi_cs/sclk/mosi/miso - card pins (CS active-low, SCLK idles
//                                        low, MOSI idles high)
//                cmd_valid, cmd_op     - opcode strobe and opcode
//                tx_data / rx_data     - word to send / last word received
//                busy                  - engine occupied, commands dropped
//                fast                  - 1 = FAST_DIV rate, 0 = SLOW_DIV rate
//  Revision    : 1.0 - initial release
// ============================================================================
module sdcard_spi_engine #(
    parameter int SLOW_DIV    = 125,
    parameter int FAST_DIV    = 1,
    parameter int INIT_CLOCKS = 80,
    parameter int DATA_W      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              spi_cs,
    output logic              spi_sclk,
    input  logic              spi_miso,
    output logic              spi_mosi,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              fast
);

    localparam int c_DIV_W    = $clog2(SLOW_DIV) + 1;
    localparam int c_EDGE_MAX = (INIT_CLOCKS > DATA_W) ? 2 * INIT_CLOCKS : 2 * DATA_W;
    localparam int c_EDGE_W   = $clog2(c_EDGE_MAX + 1);

    localparam logic [c_DIV_W-1:0]  c_SLOW_LAST  = c_DIV_W'(SLOW_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_FAST_LAST  = c_DIV_W'(FAST_DIV - 1);
    localparam logic [c_EDGE_W-1:0] c_INIT_EDGES = c_EDGE_W'(2 * INIT_CLOCKS);
    localparam logic [c_EDGE_W-1:0] c_XFER_EDGES = c_EDGE_W'(2 * DATA_W);

    localparam logic [2:0] c_OP_INIT       = 3'd1;
    localparam logic [2:0] c_OP_XFER       = 3'd2;
    localparam logic [2:0] c_OP_CS_LOW     = 3'd3;
    localparam logic [2:0] c_OP_CS_HIGH    = 3'd4;
    localparam logic [2:0] c_OP_SPEED_SLOW = 3'd5;
    localparam logic [2:0] c_OP_SPEED_FAST = 3'd6;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t              r_state,    w_state;
    logic [c_DIV_W-1:0]  r_div_cnt,  w_div_cnt;
    logic [c_EDGE_W-1:0] r_edge_cnt, w_edge_cnt;
    logic                r_sclk,     w_sclk;
    logic                r_mosi,     w_mosi;
    logic                r_cs,       w_cs;
    logic                r_busy,     w_busy;
    logic                r_fast,     w_fast;
    logic [DATA_W-1:0]   r_tx_sh,    w_tx_sh;
    logic [DATA_W-1:0]   r_rx_sh,    w_rx_sh;
    logic [DATA_W-1:0]   r_rx_data,  w_rx_data;

    logic                w_tick;
    logic [c_EDGE_W-1:0] w_edge_inc;
    logic [DATA_W-1:0]   w_rx_shift;
    logic [DATA_W-1:0]   w_tx_shift;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs       <= 1'b1;
            r_busy     <= 1'b1;
            r_fast     <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_div_cnt  <= w_div_cnt;
            r_edge_cnt <= w_edge_cnt;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_cs       <= w_cs;
            r_busy     <= w_busy;
            r_fast     <= w_fast;
            r_tx_sh    <= w_tx_sh;
            r_rx_sh    <= w_rx_sh;
            r_rx_data  <= w_rx_data;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_div_cnt  = r_div_cnt;
        w_edge_cnt = r_edge_cnt;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_cs       = r_cs;
        w_busy     = r_busy;
        w_fast     = r_fast;
        w_tx_sh    = r_tx_sh;
        w_rx_sh    = r_rx_sh;
        w_rx_data  = r_rx_data;

        // Rate is frozen while INIT/XFER run since only IDLE opcodes move it.
        w_tick     = (r_div_cnt == (r_fast ? c_FAST_LAST : c_SLOW_LAST));
        w_edge_inc = r_edge_cnt + 1'b1;
        w_rx_shift = (r_rx_sh << 1) | DATA_W'(spi_miso);
        w_tx_shift = r_tx_sh << 1;

        case (r_state)
            ST_INIT: begin
                // CS is deliberately left alone: an INIT opcode keeps framing.
                w_mosi = 1'b1;
                if (w_tick) begin
                    w_div_cnt  = '0;
                    w_sclk     = ~r_sclk;
                    w_edge_cnt = w_edge_inc;
                    if (w_edge_inc == c_INIT_EDGES) begin
                        w_state    = ST_IDLE;
                        w_busy     = 1'b0;
                        w_edge_cnt = '0;
                    end
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                w_sclk     = 1'b0;
                w_div_cnt  = '0;
                w_edge_cnt = '0;
                if (cmd_valid && !r_busy) begin
                    case (cmd_op)
                        c_OP_INIT: begin
                            w_state = ST_INIT;
                            w_busy  = 1'b1;
                            w_fast  = 1'b0;
                            w_mosi  = 1'b1;
                        end
                        c_OP_XFER: begin
                            w_state = ST_XFER;
                            w_busy  = 1'b1;
                            w_tx_sh = tx_data;
                            w_rx_sh = '0;
                            w_mosi  = tx_data[DATA_W-1];
                        end
                        c_OP_CS_LOW:     w_cs   = 1'b0;
                        c_OP_CS_HIGH:    w_cs   = 1'b1;
                        c_OP_SPEED_SLOW: w_fast = 1'b0;
                        c_OP_SPEED_FAST: w_fast = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_XFER: begin
                if (w_tick) begin
                    w_div_cnt  = '0;
                    w_edge_cnt = w_edge_inc;
                    if (w_edge_inc[0]) begin
                        // Rising edge: sample MISO.
                        w_sclk  = 1'b1;
                        w_rx_sh = w_rx_shift;
                    end else begin
                        w_sclk = 1'b0;
                        if (w_edge_inc == c_XFER_EDGES) begin
                            // Last falling edge: the final bit was captured on
                            // the preceding rising edge, so the word is whole.
                            w_rx_data  = r_rx_sh;
                            w_busy     = 1'b0;
                            w_mosi     = 1'b1;
                            w_state    = ST_IDLE;
                            w_edge_cnt = '0;
                        end else begin
                            w_tx_sh = w_tx_shift;
                            w_mosi  = w_tx_shift[DATA_W-1];
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end

            default: begin
                w_state = ST_INIT;
            end
        endcase
    end

    assign spi_cs   = r_cs;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign fast     = r_fast;

endmodule
`default_nettype wire
